// File: rtl/mux_scan_if.sv
// Bus bundle for mux_scan: channel data, select/mode/hold controls and registered outputs.
// chan_mask exists only when MUX_SCAN_MASK_EN is defined.
interface mux_scan_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
);
  localparam int SELW = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [SELW-1:0]           sel;
  logic                      mode;
  logic                      hold;
`ifdef MUX_SCAN_MASK_EN
  logic [CHANNELS-1:0]       chan_mask;
`endif
  logic [WIDTH-1:0]          data_out;
  logic [SELW-1:0]           chan;
  logic                      step;
  logic                      sel_err;

  modport master (
`ifdef MUX_SCAN_MASK_EN
    output chan_mask,
`endif
    output data_in, sel, mode, hold,
    input  data_out, chan, step, sel_err
  );

  modport slave (
`ifdef MUX_SCAN_MASK_EN
    input  chan_mask,
`endif
    input  data_in, sel, mode, hold,
    output data_out, chan, step, sel_err
  );
endinterface

// File: rtl/mux_scan.sv
// Registered N-channel multiplexer with manual select and round-robin dwell scan.
// Optional MUX_SCAN_MASK_EN adds a per-channel enable mask honoured by both modes.
module mux_scan #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 25_000_000
) (
  input  logic       clock,
  input  logic       resetn,
  mux_scan_if.slave  bus
);
  localparam int SELW = $clog2(CHANNELS);
  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

  logic [SELW-1:0]     chan_q, chan_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]    data_out_q, data_out_d;
  logic                step_q, step_d;
  logic                sel_err_q, sel_err_d;
  logic [CHANNELS-1:0] en;

`ifdef MUX_SCAN_MASK_EN
  assign en = bus.chan_mask;
`else
  assign en = '1;
`endif

  function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] d,
                                            input logic [SELW-1:0] k);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (k == SELW'(i)) r = d[i*WIDTH +: WIDTH];
    return r;
  endfunction

  // Out-of-range and masked selects are both rejected.
  function automatic logic sel_valid(input logic [SELW-1:0] s,
                                     input logic [CHANNELS-1:0] m);
    logic v;
    v = 1'b0;
    for (int i = 0; i < CHANNELS; i++)
      if (s == SELW'(i) && m[i]) v = 1'b1;
    return v;
  endfunction

  // Descending scan so the nearest enabled successor wins; no candidate means stay.
  function automatic logic [SELW-1:0] next_chan(input logic [SELW-1:0] c,
                                                input logic [CHANNELS-1:0] m);
    logic [SELW-1:0] r;
    r = c;
    for (int i = CHANNELS - 1; i >= 1; i--) begin
      automatic int j = (int'(c) + i) % CHANNELS;
      if (m[j]) r = SELW'(j);
    end
    return r;
  endfunction

  always_comb begin
    chan_d     = chan_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    sel_err_d  = sel_err_q;
    step_d     = 1'b0;
    if (!bus.hold) begin
      if (!bus.mode) begin
        cnt_d = '0;
        if (sel_valid(bus.sel, en)) begin
          chan_d    = bus.sel;
          sel_err_d = 1'b0;
        end else begin
          sel_err_d = 1'b1;
        end
      end else begin
        sel_err_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          chan_d = next_chan(chan_q, en);
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      data_out_d = pick(bus.data_in, chan_d);
      step_d     = (chan_d != chan_q);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      chan_q     <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      step_q     <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      chan_q     <= chan_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      step_q     <= step_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.chan     = chan_q;
  assign bus.step     = step_q;
  assign bus.sel_err  = sel_err_q;
endmodule

// File: doc/mux_scan.md
# mux_scan

Parametrised, registered N-channel, W-bit multiplexer for the board-level lab datapath. It replaces fixed 2:1 gate-level selection with a synchronous selector that has two modes. In manual mode the channel comes from a select input. In scan mode a dwell counter steps through the channels round-robin. The block sits between the switch/data sources and the LEDR/HEX display drivers.

## Interface
- `WIDTH`, default 4: bits per channel.
- `CHANNELS`, default 4: number of input channels, ≥2.
- `DWELL`, default 25_000_000: clock cycles spent on each channel in scan mode, ≥1.
- `SELW`, derived as `$clog2(CHANNELS)`: select/channel index width. It is not overridable.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `data_in`  in  CHANNELS*WIDTH  packed channels; channel k is `data_in[k*WIDTH +: WIDTH]`.
- `sel`  in  SELW  manual channel select.
- `mode`  in  1  0 = manual, 1 = scan.
- `hold`  in  1  1 = freeze channel index, dwell counter and `data_out`.
- `data_out`  out  WIDTH  registered selected channel data.
- `chan`  out  SELW  currently active channel index (registered).
- `step`  out  1  one-cycle pulse on the cycle `chan` changes value.
- `sel_err`  out  1  registered flag: manual `sel` ≥ CHANNELS.

## Operation
- State consists of:
  - channel register `chan`;
  - dwell counter `cnt`, width `$clog2(DWELL)` (min 1);
  - output register `data_out`;
  - flags `step` and `sel_err`.
- Reset (`resetn`=0, asynchronous):
  - `chan`=0, `cnt`=0, `data_out`=0, `step`=0, `sel_err`=0.
  - All are held while `resetn`=0, including mid-scan.
- Manual mode (`mode`=0, `hold`=0):
  - If `sel` < CHANNELS: `chan`←`sel` and `sel_err`←0.
  - If `sel` ≥ CHANNELS: `chan` keeps its value and `sel_err`←1.
  - `cnt`←0.
- Scan mode (`mode`=1, `hold`=0):
  - If `cnt`==DWELL-1: `cnt`←0 and `chan`←next channel. Next channel is `chan`+1, wrapping CHANNELS-1→0.
  - Otherwise `cnt`←`cnt`+1.
  - `sel` is ignored and `sel_err`←0.
- Mode switch:
  - Manual→scan: scanning resumes from the current `chan` with `cnt`=0, so that channel gets a full DWELL.
  - Scan→manual: `sel` takes effect on the next edge.
- Hold (`hold`=1):
  - `chan`, `cnt`, `data_out` and `sel_err` are all frozen.
  - `step`=0.
  - Hold has priority over `mode`.
- Output:
  - Every non-held cycle, `data_out` ← slice of `data_in` for the channel value being written into `chan` that cycle.
  - `data_out` therefore always matches the data of the `chan` shown on the same cycle, as sampled one edge earlier.
- `step` is 1 for exactly the cycle after an edge where `chan` changed. This covers both a manual change and a scan advance.
- DWELL=1: `chan` advances every cycle in scan mode.

## Timing
- Manual latency: `sel`/`data_in` change → `chan`, `data_out` and `sel_err` updated at the first rising edge, i.e. 1 cycle.
- Scan period: `chan` changes every DWELL cycles exactly. A full rotation takes CHANNELS*DWELL cycles.
- First scan advance after reset with `mode`=1 held: DWELL edges after reset release, with `chan` going 0→1.
- Reset assertion clears outputs immediately (asynchronous). Release takes effect at the next edge.
- No combinational path from any input to any output.

## Configuration
- Macro: `MUX_SCAN_MASK_EN`.
- Defined:
  - Adds input `chan_mask` [CHANNELS-1:0], where 1 = channel enabled.
  - Scan advance moves to the next enabled channel after `chan`, wrapping. If `chan` is the only enabled channel, it stays and no `step` is issued.
  - If all channels are masked, `chan` holds and `cnt` still counts and wraps.
  - Manual `sel` to a masked channel behaves as out-of-range: `chan` holds and `sel_err`=1.
- Undefined: the port is absent and all channels are always enabled.

## Test plan
- Reset: assert `resetn`=0 mid-scan with `chan`=2 → `chan`=0, `data_out`=0, `step`=0, `sel_err`=0 immediately; after release with `mode`=1 and DWELL=3, `chan`=1 after 3 edges.
- Manual select: CHANNELS=4, WIDTH=4, `data_in`=16'hD2A5, `sel`=2 → after 1 edge `data_out`=4'h2, `chan`=2, `step`=1 for 1 cycle.
- Out-of-range: CHANNELS=3, `sel`=3 → `sel_err`=1, `chan` and `data_out` unchanged; `sel`=1 → `sel_err`=0 after 1 edge.
- Scan wrap: DWELL=2, CHANNELS=4, `mode`=1 → `chan` sequence 0,0,1,1,2,2,3,3,0, with `step` on each change.
- Hold: assert `hold` at `cnt`=1, `chan`=2 for 5 cycles → nothing changes and `step`=0; release → advance occurs DWELL-1 cycles later.
- Mask (`MUX_SCAN_MASK_EN`): `chan_mask`=4'b1010, DWELL=1, scan → `chan` sequence 1,3,1,3; `chan_mask`=0 → `chan` frozen.
